// File: rtl/three_to_eight_decoder_seq.sv
// -----------------------------------------------------------------------------
// three_to_eight_decoder_seq
//
// Registered 3-to-8 one-hot decoder. An upstream producer offers a 3-bit code
// with a valid/ready handshake. An accepted code is decoded onto a glitch-free,
// registered one-hot bus. The bus either holds the code (mode 0) or strobes it
// for PULSE_LEN cycles (mode 1). A saturating counter tracks accepted codes.
//
// Parameters:
//   PULSE_LEN  cycles the one-hot output stays asserted in pulse mode (1..255)
//   CNT_W      width of dec_count
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   enable     block enable; low blocks acceptance and clears the output
//   in_valid   in_code is valid this cycle
//   in_ready   block can accept a code this cycle (combinational)
//   in_code    binary code to decode
//   mode       0 = hold, 1 = pulse; sampled only on an accepted transfer
//   outpt      registered one-hot output; zero when inactive
//   out_valid  high exactly when outpt is non-zero
//   busy       high while a pulse is in progress
//   dec_count  number of accepted codes, saturating at all-ones
// -----------------------------------------------------------------------------
module three_to_eight_decoder_seq #(
  parameter int PULSE_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_code,
  input  logic             mode,
  output logic [7:0]       outpt,
  output logic             out_valid,
  output logic             busy,
  output logic [CNT_W-1:0] dec_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_PULSE = 2'd2
  } state_t;

  // The pulse counter counts the remaining cycles after the first strobe cycle,
  // so a load of PULSE_LEN-1 yields exactly PULSE_LEN asserted cycles.
  localparam logic [7:0] PULSE_INIT = 8'(PULSE_LEN - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [7:0] onehot(input logic [2:0] code);
    return 8'd1 << code;
  endfunction

  state_t           state_q,     state_d;
  logic [7:0]       outpt_q,     outpt_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       pulse_cnt_q, pulse_cnt_d;
  logic [CNT_W-1:0] dec_count_q, dec_count_d;
  logic             accept;

  // Ready depends only on state and enable, never on in_valid.
  assign in_ready = enable && (state_q != S_PULSE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    outpt_d     = outpt_q;
    out_valid_d = out_valid_q;
    pulse_cnt_d = pulse_cnt_q;
    dec_count_d = dec_count_q;

    if (accept) begin
      dec_count_d = sat_inc(dec_count_q);
    end

    case (state_q)
      S_IDLE, S_HOLD: begin
        if (!enable) begin
          outpt_d     = 8'h00;
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else if (accept) begin
          outpt_d     = onehot(in_code);
          out_valid_d = 1'b1;
          if (mode) begin
            state_d     = S_PULSE;
            pulse_cnt_d = PULSE_INIT;
          end else begin
            state_d     = S_HOLD;
          end
        end
      end
      S_PULSE: begin
        // Enable-low aborts the pulse ahead of normal expiry.
        if (!enable || (pulse_cnt_q == 8'd0)) begin
          outpt_d     = 8'h00;
          out_valid_d = 1'b0;
          pulse_cnt_d = 8'd0;
          state_d     = S_IDLE;
        end else begin
          pulse_cnt_d = pulse_cnt_q - 8'd1;
        end
      end
      default: begin
        outpt_d     = 8'h00;
        out_valid_d = 1'b0;
        pulse_cnt_d = 8'd0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // ---- register stage: state, one-hot bus, pulse timer, accept counter ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      outpt_q     <= 8'h00;
      out_valid_q <= 1'b0;
      pulse_cnt_q <= 8'd0;
      dec_count_q <= '0;
    end else begin
      state_q     <= state_d;
      outpt_q     <= outpt_d;
      out_valid_q <= out_valid_d;
      pulse_cnt_q <= pulse_cnt_d;
      dec_count_q <= dec_count_d;
    end
  end

  assign outpt     = outpt_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == S_PULSE);
  assign dec_count = dec_count_q;

endmodule

// File: tb/tb_three_to_eight_decoder_seq.sv
module tb_three_to_eight_decoder_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_code = 3'd0;
  logic       mode = 1'b0;

  // Two instances share the stimulus: a 4-cycle pulse with a wide counter, and
  // a single-cycle strobe with a 2-bit counter that saturates quickly.
  logic       rdy_a, ov_a, busy_a;
  logic [7:0] out_a;
  logic [7:0] cnt_a;
  logic       rdy_b, ov_b, busy_b;
  logic [7:0] out_b;
  logic [1:0] cnt_b;

  three_to_eight_decoder_seq #(.PULSE_LEN(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid),
    .in_ready(rdy_a), .in_code(in_code), .mode(mode), .outpt(out_a),
    .out_valid(ov_a), .busy(busy_a), .dec_count(cnt_a)
  );

  three_to_eight_decoder_seq #(.PULSE_LEN(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid),
    .in_ready(rdy_b), .in_code(in_code), .mode(mode), .outpt(out_b),
    .out_valid(ov_b), .busy(busy_b), .dec_count(cnt_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] out;
    logic       ov;
    logic       busy;
    logic       rdy;
    int         cnt;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int tests = 0;
  int fails = 0;

  // Reference model: the visible output value, how many more cycles it stays
  // visible in pulse mode (0 = held or idle), and the accept count.
  int         plen[2] = '{4, 1};
  int         cmax[2] = '{255, 3};
  logic [7:0] m_out[2] = '{8'h00, 8'h00};
  int         m_left[2] = '{0, 0};
  int         m_cnt[2] = '{0, 0};

  function automatic exp_t expect_now(input int d, input logic e);
    exp_t x;
    x.out  = m_out[d];
    x.ov   = (m_out[d] != 8'h00);
    x.busy = (m_left[d] > 0);
    x.rdy  = e && (m_left[d] == 0);
    x.cnt  = m_cnt[d];
    return x;
  endfunction

  function automatic void advance(input int d, input logic r, input logic e,
                                  input logic v, input logic [2:0] c,
                                  input logic md);
    logic [7:0] oh;
    oh = 8'h00;
    oh[c] = 1'b1;
    if (r) begin
      m_out[d] = 8'h00; m_left[d] = 0; m_cnt[d] = 0;
    end else if (!e) begin
      m_out[d] = 8'h00; m_left[d] = 0;
    end else if (v && m_left[d] == 0) begin
      m_out[d]  = oh;
      m_left[d] = md ? plen[d] : 0;
      m_cnt[d]  = (m_cnt[d] < cmax[d]) ? m_cnt[d] + 1 : m_cnt[d];
    end else if (m_left[d] > 0) begin
      m_left[d] = m_left[d] - 1;
      if (m_left[d] == 0) m_out[d] = 8'h00;
    end
  endfunction

  task automatic step(input logic r, input logic e, input logic v,
                      input logic [2:0] c, input logic md);
    @(posedge clk);
    #1;
    rst = r; enable = e; in_valid = v; in_code = c; mode = md;
    q_a.push_back(expect_now(0, e));
    q_b.push_back(expect_now(1, e));
    advance(0, r, e, v, c, md);
    advance(1, r, e, v, c, md);
  endtask

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: the DUT presents its outputs every cycle; compare mid-cycle.
  always @(negedge clk) begin
    exp_t x;
    if (q_a.size() > 0) begin
      x = q_a.pop_front();
      chk("a.outpt",     int'(out_a),  int'(x.out));
      chk("a.out_valid", int'(ov_a),   int'(x.ov));
      chk("a.busy",      int'(busy_a), int'(x.busy));
      chk("a.in_ready",  int'(rdy_a),  int'(x.rdy));
      chk("a.dec_count", int'(cnt_a),  x.cnt);
    end
    if (q_b.size() > 0) begin
      x = q_b.pop_front();
      chk("b.outpt",     int'(out_b),  int'(x.out));
      chk("b.out_valid", int'(ov_b),   int'(x.ov));
      chk("b.busy",      int'(busy_b), int'(x.busy));
      chk("b.in_ready",  int'(rdy_b),  int'(x.rdy));
      chk("b.dec_count", int'(cnt_b),  x.cnt);
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    step(1, 0, 0, 3'd0, 0);
    step(0, 1, 0, 3'd0, 0);

    // Hold mode, codes 0..7 back-to-back.
    for (int i = 0; i < 8; i++) step(0, 1, 1, 3'(i), 0);
    step(0, 1, 0, 3'd0, 0);

    // Pulse of code 5, with code 2 waiting behind it.
    step(0, 1, 1, 3'd5, 1);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 3'd2, 0);
    step(0, 1, 0, 3'd0, 0);

    // Enable drop while holding code 3, with in_valid still high.
    step(0, 1, 1, 3'd3, 0);
    step(0, 0, 1, 3'd3, 0);
    step(0, 1, 0, 3'd0, 0);

    // Reset in the middle of a pulse of code 7, alongside an offered code.
    step(0, 1, 1, 3'd7, 1);
    step(0, 1, 0, 3'd0, 0);
    step(1, 1, 1, 3'd4, 0);
    step(0, 1, 0, 3'd0, 0);

    // Continuous offers in pulse mode.
    for (int i = 0; i < 8; i++) step(0, 1, 1, 3'd1, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)));
    end

    step(0, 1, 0, 3'd0, 0);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", q_a.size() + q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
